// File: rtl/banco_de_registros.sv
// Eight 16-bit registers on one bidirectional bus. Words are accessible on R0..R7
// and bytes on R0..R3; reads are combinational and writes happen on the rising clk edge.
module banco_de_registros (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  select_reg,
    input  logic        size,
    input  logic        select_high_low,
    input  logic        select_data_h_reg,
    input  logic        read_write,
    inout  logic [15:0] data
);

    logic [15:0] reg_word [8];
    logic [15:0] sel_word;
    logic [7:0]  sel_byte;
    logic [15:0] rd_data;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            logic [15:0] reg_q;
            logic [15:0] reg_d;

            always_comb begin
                reg_d = reg_q;
                if (read_write && (select_reg == 3'(gi))) begin
                    if (size) begin
                        reg_d = data;
                    end else if (gi < 4) begin
                        // A byte write always takes its value from data[7:0].
                        if (select_high_low) begin
                            reg_d[15:8] = data[7:0];
                        end else begin
                            reg_d[7:0] = data[7:0];
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    reg_q <= 16'h0000;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign reg_word[gi] = reg_q;
        end
    endgenerate

    always_comb begin
        sel_word = reg_word[select_reg];
        sel_byte = select_high_low ? sel_word[15:8] : sel_word[7:0];
        rd_data  = 16'h0000;
        if (size) begin
            rd_data = sel_word;
        end else if (!select_reg[2]) begin
            rd_data = select_data_h_reg ? {sel_byte, 8'h00} : {8'h00, sel_byte};
        end
    end

    // The bank drives the bus on every read cycle, even while reset is asserted.
    assign data = read_write ? 16'hzzzz : rd_data;

endmodule

// File: tb/tb_banco_de_registros.sv
// Testbench for banco_de_registros. Directed scenarios run first, then randomized
// traffic; all of it is checked each cycle against an array-based model.
module tb_banco_de_registros;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel;
    logic        size;
    logic        shl;
    logic        sdh;
    logic        rw;
    logic [15:0] tb_drv;
    wire  [15:0] data;

    logic [15:0] model [8];
    logic        chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    assign data = rw ? tb_drv : 16'hzzzz;

    always #5 clk = ~clk;

    banco_de_registros dut (
        .clk               (clk),
        .reset             (reset),
        .select_reg        (sel),
        .size              (size),
        .select_high_low   (shl),
        .select_data_h_reg (sdh),
        .read_write        (rw),
        .data              (data)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_read();
        logic [7:0] b;
        if (size) return model[sel];
        if (sel > 3'd3) return 16'h0000;
        b = shl ? model[sel][15:8] : model[sel][7:0];
        return sdh ? {b, 8'h00} : {8'h00, b};
    endfunction

    // The model applies the specified register update at every rising edge.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        end else if (rw) begin
            if (size) begin
                model[sel] = tb_drv;
            end else if (sel <= 3'd3) begin
                if (shl) model[sel][15:8] = tb_drv[7:0];
                else     model[sel][7:0]  = tb_drv[7:0];
            end
        end
    end

    // On a write cycle, the bus has to carry only the bench's value because the bank is released.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rw) check("bus_read", data, exp_read());
            else     check("bus_release", data, tb_drv);
        end
    end

    task automatic cycle(input logic r, input logic [2:0] s, input logic sz, input logic hl,
                         input logic dh, input logic w, input logic [15:0] d);
        @(posedge clk);
        #1;
        reset = r; sel = s; size = sz; shl = hl; sdh = dh; rw = w; tb_drv = d;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] s, input logic sz,
                          input logic hl, input logic dh, input logic [15:0] exp);
        cycle(1'b1, s, sz, hl, dh, 1'b0, 16'h0000);
        @(negedge clk);
        #1;
        check(name, data, exp);
        $display("rd %-12s R%0d size=%0d hl=%0d dh=%0d data=%h exp=%h", name, s, sz, hl, dh, data, exp);
    endtask

    initial begin
        reset = 1'b0; sel = 3'd0; size = 1'b1; shl = 1'b0; sdh = 1'b0; rw = 1'b0; tb_drv = 16'h0000;
        // Reset is held for two edges and then released.
        cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_en = 1'b1;
        for (int i = 0; i < 8; i++) rd_chk("reset_word", 3'(i), 1'b1, 1'b0, 1'b0, 16'h0000);

        cycle(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        rd_chk("word_r5", 3'd5, 1'b1, 1'b0, 1'b0, 16'hBEEF);
        rd_chk("word_r4", 3'd4, 1'b1, 1'b0, 1'b0, 16'h0000);
        rd_chk("word_r6", 3'd6, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("model_r5", model[5], 16'hBEEF);

        cycle(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0034);
        cycle(1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFF12);
        rd_chk("byte_r2", 3'd2, 1'b1, 1'b0, 1'b0, 16'h1234);
        cycle(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AA);
        rd_chk("byte_keep", 3'd2, 1'b1, 1'b0, 1'b0, 16'h12AA);
        check("model_r2", model[2], 16'h12AA);

        rd_chk("align_low", 3'd2, 1'b0, 1'b1, 1'b0, 16'h0012);
        rd_chk("align_high", 3'd2, 1'b0, 1'b1, 1'b1, 16'h1200);
        rd_chk("lowbyte_hi", 3'd2, 1'b0, 1'b0, 1'b1, 16'hAA00);

        cycle(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555);
        cycle(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        cycle(1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        rd_chk("illegal_word", 3'd6, 1'b1, 1'b0, 1'b0, 16'h5555);
        rd_chk("illegal_byte", 3'd6, 1'b0, 1'b0, 1'b0, 16'h0000);
        rd_chk("illegal_bh", 3'd6, 1'b0, 1'b1, 1'b1, 16'h0000);

        cycle(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hCAFE);
        rd_chk("r1_cafe", 3'd1, 1'b1, 1'b0, 1'b0, 16'hCAFE);
        cycle(1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1111);
        rd_chk("rst_prio", 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000);
        rd_chk("rst_r5", 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("model_r1", model[1], 16'h0000);

        // Randomized traffic with occasional resets; the per-cycle compare does the checking.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 59) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        end
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
